fpmul_operand_unpack: RTL and testbench

// - Input-side counterpart of the multiplier's output normalizer: unpacks two packed

---
 rtl/fpmul_operand_unpack.sv | 167 ++++++++++++++++
 tb/tb_fpmul_operand_unpack.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpmul_operand_unpack.sv
// fpmul_operand_unpack: unpacks two packed IEEE-754 operands into sign, exponent,
// significand and special-case flags for the multiplier array.
// Two-stage valid/ready pipeline: S1 holds the raw operands, S2 holds the decoded fields.
// Optional feature macro: DENORM_PRENORM_EN (pre-normalise denormal significands).
module fpmul_operand_unpack #(
    parameter int unsigned EXPWIDTH = 8,
    parameter int unsigned MANWIDTH = 23,
    parameter int unsigned BIAS     = 127
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [EXPWIDTH+MANWIDTH:0]     a,
    input  logic [EXPWIDTH+MANWIDTH:0]     b,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           prod_sign,
    output logic signed [EXPWIDTH+1:0]     a_exp,
    output logic signed [EXPWIDTH+1:0]     b_exp,
    output logic [MANWIDTH:0]              a_sig,
    output logic [MANWIDTH:0]              b_sig,
    output logic                           res_zero,
    output logic                           res_inf,
    output logic                           res_nan,
    output logic                           invalid
);

    localparam int unsigned OPW      = 1 + EXPWIDTH + MANWIDTH;
    localparam int unsigned SIGWIDTH = MANWIDTH + 1;
    localparam int unsigned EW2      = EXPWIDTH + 2;
    localparam int unsigned LZW      = $clog2(SIGWIDTH + 1);

    // Denormals live at the minimum unbiased exponent 1-BIAS; outputs stay biased.
    localparam int            EMIN_UNB   = 1 - int'(BIAS);
    localparam logic [EW2-1:0] EXP_DENORM = EW2'(EMIN_UNB + int'(BIAS));

    typedef struct packed {
        logic                zero;
        logic                inf;
        logic                nan;
        logic [EW2-1:0]      exp;
        logic [SIGWIDTH-1:0] sig;
    } dec_t;

`ifdef DENORM_PRENORM_EN
    // Leading-zero count of a significand (SIGWIDTH when all zero).
    function automatic logic [LZW-1:0] lzc(input logic [SIGWIDTH-1:0] v);
        logic [LZW-1:0] n;
        logic           hit;
        n   = '0;
        hit = 1'b0;
        for (int i = SIGWIDTH - 1; i >= 0; i--) begin
            if (!hit) begin
                if (v[i]) hit = 1'b1;
                else      n   = n + LZW'(1);
            end
        end
        return n;
    endfunction
`endif

    // Classify one operand and restore its implied bit. Inf/NaN keep {1,frac} and the
    // raw exponent field; downstream only looks at the flags for those classes.
    function automatic dec_t decode(input logic [OPW-1:0] x);
        logic [EXPWIDTH-1:0] ef;
        logic [MANWIDTH-1:0] f;
        dec_t                d;
`ifdef DENORM_PRENORM_EN
        logic [LZW-1:0]      lz;
`endif
        ef     = x[OPW-2 -: EXPWIDTH];
        f      = x[MANWIDTH-1:0];
        d      = '0;
        d.zero = (ef == '0) && (f == '0);
        d.inf  = (ef == '1) && (f == '0);
        d.nan  = (ef == '1) && (f != '0);
        if (ef == '0) begin
`ifdef DENORM_PRENORM_EN
            lz    = lzc({1'b0, f});
            d.sig = SIGWIDTH'({1'b0, f} << lz);
            d.exp = (f == '0) ? EXP_DENORM : EXP_DENORM - EW2'(lz);
`else
            d.sig = {1'b0, f};
            d.exp = EXP_DENORM;
`endif
        end else begin
            d.sig = {1'b1, f};
            d.exp = EW2'(ef);
        end
        return d;
    endfunction

    logic           s1_valid;
    logic [OPW-1:0] s1_a;
    logic [OPW-1:0] s1_b;
    logic           s2_ready;
    logic           s1_adv;
    logic           s1_load;
    dec_t           da;
    dec_t           db;
    logic           inv_c;
    logic           nan_c;
    logic           inf_c;
    logic           zero_c;

    // Handshake: S1 moves on when S2 is empty or being drained.
    assign s2_ready = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_ready;
    assign in_ready = !s1_valid || s1_adv;
    assign s1_load  = in_valid && in_ready;

    // Decode S1 operands and resolve product flags (NaN dominates inf and zero).
    always_comb begin
        da     = decode(s1_a);
        db     = decode(s1_b);
        inv_c  = (da.zero && db.inf) || (da.inf && db.zero);
        nan_c  = da.nan || db.nan || inv_c;
        inf_c  = !nan_c && (da.inf || db.inf);
        zero_c = !nan_c && (da.zero || db.zero);
    end

    // Stage 1: capture raw operand pair.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            s1_a     <= a;
            s1_b     <= b;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: decoded fields drive the outputs directly and hold while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            prod_sign <= 1'b0;
            a_exp     <= '0;
            b_exp     <= '0;
            a_sig     <= '0;
            b_sig     <= '0;
            res_zero  <= 1'b0;
            res_inf   <= 1'b0;
            res_nan   <= 1'b0;
            invalid   <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= 1'b1;
            prod_sign <= s1_a[OPW-1] ^ s1_b[OPW-1];
            a_exp     <= da.exp;
            b_exp     <= db.exp;
            a_sig     <= da.sig;
            b_sig     <= db.sig;
            res_zero  <= zero_c;
            res_inf   <= inf_c;
            res_nan   <= nan_c;
            invalid   <= inv_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fpmul_operand_unpack.sv
// Testbench for fpmul_operand_unpack: directed steps plus a scoreboard that predicts
// every unpacked pair from an independent reference decoder.
module tb_fpmul_operand_unpack;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic        prod_sign;
    logic signed [9:0] a_exp;
    logic signed [9:0] b_exp;
    logic [23:0] a_sig;
    logic [23:0] b_sig;
    logic        res_zero;
    logic        res_inf;
    logic        res_nan;
    logic        invalid;

    typedef struct packed {
        logic        sgn;
        logic [9:0]  ae;
        logic [23:0] as;
        logic [9:0]  be;
        logic [23:0] bs;
        logic        z;
        logic        i;
        logic        n;
        logic        inv;
    } res_t;

    res_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_out = 0;

    fpmul_operand_unpack #(.EXPWIDTH(8), .MANWIDTH(23), .BIAS(127)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .prod_sign(prod_sign), .a_exp(a_exp), .b_exp(b_exp),
        .a_sig(a_sig), .b_sig(b_sig), .res_zero(res_zero), .res_inf(res_inf),
        .res_nan(res_nan), .invalid(invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500us");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference decode of one binary32 operand.
    function automatic void ref_dec(input logic [31:0] x, output logic [9:0] e,
                                    output logic [23:0] s, output logic z,
                                    output logic inf, output logic nan);
        logic [7:0]  ef;
        logic [22:0] f;
        int          sh;
        ef  = x[30:23];
        f   = x[22:0];
        z   = (ef == 8'h00) && (f == 23'h0);
        inf = (ef == 8'hFF) && (f == 23'h0);
        nan = (ef == 8'hFF) && (f != 23'h0);
        if (ef == 8'h00) begin
            e = 10'd1;
            s = {1'b0, f};
`ifdef DENORM_PRENORM_EN
            if (f != 23'h0) begin
                sh = 0;
                while (!s[23]) begin
                    s  = s << 1;
                    sh = sh + 1;
                end
                e = 10'(1 - sh);
            end
`endif
        end else begin
            e = {2'b00, ef};
            s = {1'b1, f};
        end
    endfunction

    function automatic res_t model(input logic [31:0] x, input logic [31:0] y);
        res_t r;
        logic az, ai, an, bz, bi, bn;
        ref_dec(x, r.ae, r.as, az, ai, an);
        ref_dec(y, r.be, r.bs, bz, bi, bn);
        r.sgn = x[31] ^ y[31];
        r.inv = (az && bi) || (ai && bz);
        r.n   = an || bn || r.inv;
        r.i   = !r.n && (ai || bi);
        r.z   = !r.n && (az || bz);
        return r;
    endfunction

    function automatic res_t obs_now();
        res_t o;
        o.sgn = prod_sign;
        o.ae  = a_exp;
        o.as  = a_sig;
        o.be  = b_exp;
        o.bs  = b_sig;
        o.z   = res_zero;
        o.i   = res_inf;
        o.n   = res_nan;
        o.inv = invalid;
        return o;
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0: r[30:0] = 31'h0;
            1: r[30:23] = 8'h00;
            2: begin r[30:23] = 8'hFF; r[22:0] = 23'h0; end
            3: begin r[30:23] = 8'hFF; r[22] = 1'b1; end
            default: r[30:23] = 8'($urandom_range(1, 254));
        endcase
        return r;
    endfunction

    // Scoreboard: compare on each output transfer, predict on each input transfer.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                n_cmp++;
                assert (sb.size() != 0) else begin
                    n_err++;
                    $error("FAIL sb_extra: observed output 0x%0h expected none", obs_now());
                end
                if (sb.size() != 0) chk("sb_data", 80'(obs_now()), 80'(sb.pop_front()));
                n_out++;
            end
            if (in_valid && in_ready) sb.push_back(model(a, b));
        end
    end

    task automatic send(input logic [31:0] x, input logic [31:0] y);
        logic ok;
        in_valid = 1'b1;
        a = x;
        b = y;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        chk("accept_wait", 80'(ok), 80'(1'b1));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1'b1; break; end
        end
        chk("out_wait", 80'(ok), 80'(1'b1));
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
        chk("drain_empty", 80'(sb.size()), 80'(0));
        @(posedge clk);
        #1;
    endtask

    logic [31:0] pa [3];
    logic [31:0] pb [3];
    int          idx;
    int          out0;
    logic        acc;
    logic        stale;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 80'(out_valid), 80'(1'b0));
        chk("rst_in_ready", 80'(in_ready), 80'(1'b1));
        chk("rst_outputs", 80'(obs_now()), 80'(0));
        @(posedge clk);
        #1 reset = 1'b0;

        // 1.5 x -2.0, two-cycle latency
        out_ready = 1'b1;
        a = 32'h3FC00000;
        b = 32'hC0000000;
        in_valid = 1'b1;
        @(negedge clk);
        chk("lat_in_ready", 80'(in_ready), 80'(1'b1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("lat_cycle1_valid", 80'(out_valid), 80'(1'b0));
        @(negedge clk);
        chk("lat_cycle2_valid", 80'(out_valid), 80'(1'b1));
        chk("mul_sign", 80'(prod_sign), 80'(1'b1));
        chk("mul_a_sig", 80'(a_sig), 80'(24'hC00000));
        chk("mul_a_exp", 80'($unsigned(a_exp)), 80'(10'd127));
        chk("mul_b_sig", 80'(b_sig), 80'(24'h800000));
        chk("mul_b_exp", 80'($unsigned(b_exp)), 80'(10'd128));
        chk("mul_flags", 80'({res_zero, res_inf, res_nan, invalid}), 80'(4'b0000));
        @(posedge clk);
        #1;

        // 0 x inf
        send(32'h00000000, 32'h7F800000);
        wait_out();
        chk("zinf_flags", 80'({res_zero, res_inf, res_nan, invalid}), 80'(4'b0011));
        @(posedge clk);
        #1;

        // -0 x -inf keeps sign, inf x finite
        send(32'h80000000, 32'hFF800000);
        wait_out();
        chk("zinf_sign", 80'(prod_sign), 80'(1'b0));
        @(posedge clk);
        #1;
        send(32'h7F800000, 32'hBF800000);
        wait_out();
        chk("inf_flags", 80'({res_zero, res_inf, res_nan, invalid, prod_sign}), 80'(5'b01001));
        @(posedge clk);
        #1;

        // smallest denormal x 1.0
        send(32'h00000001, 32'h3F800000);
        wait_out();
`ifdef DENORM_PRENORM_EN
        chk("den_a_sig", 80'(a_sig), 80'(24'h800000));
        chk("den_a_exp", 80'($unsigned(a_exp)), 80'(10'h3EA));
`else
        chk("den_a_sig", 80'(a_sig), 80'(24'h000001));
        chk("den_a_exp", 80'($unsigned(a_exp)), 80'(10'd1));
`endif
        chk("den_b_sig", 80'(b_sig), 80'(24'h800000));
        chk("den_b_exp", 80'($unsigned(b_exp)), 80'(10'd127));
        chk("den_flags", 80'({res_zero, res_inf, res_nan, invalid}), 80'(4'b0000));
        drain();

        // backpressure: three pairs, out_ready low for five cycles
        pa[0] = 32'h40400000; pb[0] = 32'h3F000000;
        pa[1] = 32'hC1200000; pb[1] = 32'h00400000;
        pa[2] = 32'h7FC00001; pb[2] = 32'h42F60000;
        out_ready = 1'b0;
        out0 = n_out;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (idx < 3);
            a = pa[idx % 3];
            b = pb[idx % 3];
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        chk("bp_accepts", 80'(idx), 80'(2));
        @(negedge clk);
        chk("bp_in_ready", 80'(in_ready), 80'(1'b0));
        chk("bp_out_valid", 80'(out_valid), 80'(1'b1));
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(pa[2], pb[2]);
        drain();
        chk("bp_count", 80'(n_out - out0), 80'(3));

        // streaming eight pairs at full rate
        out0 = n_out;
        for (int k = 0; k < 10; k++) begin
            in_valid = (k < 8);
            a = rnd_op();
            b = rnd_op();
            @(negedge clk);
            if (k < 8) chk("stream_in_ready", 80'(in_ready), 80'(1'b1));
            chk("stream_out_valid", 80'(out_valid), 80'(k >= 2));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();
        chk("stream_count", 80'(n_out - out0), 80'(8));

        // random traffic with random backpressure
        for (int k = 0; k < 60; k++) begin
            in_valid  = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 2) != 0;
            a = rnd_op();
            b = rnd_op();
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // reset with two pairs in flight
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            a = rnd_op();
            b = rnd_op();
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_inflight", 80'(out_valid), 80'(1'b1));
        #1 reset = 1'b1;
        #1;
        chk("rst_async_valid", 80'(out_valid), 80'(1'b0));
        chk("rst_async_outputs", 80'(obs_now()), 80'(0));
        chk("rst_async_in_ready", 80'(in_ready), 80'(1'b1));
        sb.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        stale = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        chk("rst_no_stale", 80'(stale), 80'(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
